apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_master_pkg.sv | 23 ++
 rtl/apb_wait_timer.sv | 29 ++
 rtl/apb_cmd_master.sv | 170 +++++++++++++++++
 tb/tb_apb_cmd_master.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared constants, FSM encoding and helpers for the APB command master.
package apb_master_pkg;

  localparam int DEF_ADDR_WIDTH     = 16;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int WAIT_CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Clamp an integer cycle limit into the wait counter range; 0 keeps the timeout disabled.
  function automatic logic [WAIT_CNT_WIDTH-1:0] wait_limit(input int cycles);
    if (cycles <= 0) return '0;
    if (cycles >= (1 << WAIT_CNT_WIDTH) - 1) return '1;
    return WAIT_CNT_WIDTH'(cycles);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter with a compare against the timeout limit.
module apb_wait_timer
  import apb_master_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      run,
  input  logic [WAIT_CNT_WIDTH-1:0] limit,
  output logic                      expired
);

  logic [WAIT_CNT_WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != '1)) begin
      r_count <= r_count + WAIT_CNT_WIDTH'(1);
    end
  end

  // The count holds the number of wait cycles already seen in this ACCESS phase.
  assign expired = (limit != '0) && (r_count == limit);

endmodule

// File: rtl/apb_cmd_master.sv
// Command/response to APB bridge: one transfer at a time, all outputs registered.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    apb_psel,
  output logic                    apb_penable,
  output logic                    apb_pwrite,
  output logic [ADDR_WIDTH-1:0]   apb_paddr,
  output logic [DATA_WIDTH-1:0]   apb_pwdata,
  output logic [DATA_WIDTH/8-1:0] apb_pstrb,
  output logic [2:0]              apb_pprot,
  input  logic [DATA_WIDTH-1:0]   apb_prdata,
  input  logic                    apb_pready,
  input  logic                    apb_pslverr
);

  localparam int                        STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [WAIT_CNT_WIDTH-1:0] LP_LIMIT   = wait_limit(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0]     LP_ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  apb_state_e              r_state, w_state_nxt;
  logic                    r_cmd_ready, w_cmd_ready_nxt;
  logic                    r_psel, w_psel_nxt;
  logic                    r_penable, w_penable_nxt;
  logic                    r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0]   r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0]   r_pwdata, w_pwdata_nxt;
  logic [STRB_WIDTH-1:0]   r_pstrb, w_pstrb_nxt;
  logic [2:0]              r_pprot, w_pprot_nxt;
  logic                    r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                    r_rsp_err, w_rsp_err_nxt;
  logic                    r_rsp_timeout, w_rsp_timeout_nxt;
  logic                    w_expired;

  apb_wait_timer u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state != ST_ACCESS),
    .run     ((r_state == ST_ACCESS) && !apb_pready),
    .limit   (LP_LIMIT),
    .expired (w_expired)
  );

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt       = r_state;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_pstrb_nxt       = r_pstrb;
    w_pprot_nxt       = r_pprot;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state_nxt   = ST_SETUP;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_pwrite_nxt  = cmd_write;
          w_paddr_nxt   = cmd_addr & LP_ADDR_MASK;
          w_pwdata_nxt  = cmd_wdata;
          w_pstrb_nxt   = cmd_write ? cmd_strb : '0;
          w_pprot_nxt   = cmd_prot;
        end
      end
      ST_SETUP: begin
        w_state_nxt   = ST_ACCESS;
        w_penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        // A slave answer on the limit cycle wins over the timeout.
        if (apb_pready) begin
          w_state_nxt       = ST_RESP;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = r_pwrite ? '0 : apb_prdata;
          w_rsp_err_nxt     = apb_pslverr;
          w_rsp_timeout_nxt = 1'b0;
        end else if (w_expired) begin
          w_state_nxt       = ST_RESP;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = '0;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_pstrb       <= w_pstrb_nxt;
      r_pprot       <= w_pprot_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign apb_psel    = r_psel;
  assign apb_penable = r_penable;
  assign apb_pwrite  = r_pwrite;
  assign apb_paddr   = r_paddr;
  assign apb_pwdata  = r_pwdata;
  assign apb_pstrb   = r_pstrb;
  assign apb_pprot   = r_pprot;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed table, reset corner case, random traffic.
module tb_apb_cmd_master;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int T     = 4;
  localparam int BOUND = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          apb_psel;
  logic          apb_penable;
  logic          apb_pwrite;
  logic [AW-1:0] apb_paddr;
  logic [DW-1:0] apb_pwdata;
  logic [SW-1:0] apb_pstrb;
  logic [2:0]    apb_pprot;
  logic [DW-1:0] apb_prdata = '0;
  logic          apb_pready = 1'b0;
  logic          apb_pslverr = 1'b0;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .cmd_prot    (cmd_prot),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_paddr   (apb_paddr),
    .apb_pwdata  (apb_pwdata),
    .apb_pstrb   (apb_pstrb),
    .apb_pprot   (apb_pprot),
    .apb_prdata  (apb_prdata),
    .apb_pready  (apb_pready),
    .apb_pslverr (apb_pslverr)
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            waits;      // ACCESS cycles with pready=0 before the slave answers
    logic [DW-1:0] prdata;
    logic          slverr;
    int            rsp_delay;  // cycles rsp_ready is held low
    logic [AW-1:0] e_paddr;
    logic [SW-1:0] e_pstrb;
    logic          e_err;
    logic          e_tmo;
    logic [DW-1:0] e_rdata;
    int            e_lat;      // accept edge to first rsp_valid cycle
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour: timeout fires only if the slave would need more than T wait cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   tmo;
    int   access_cycles;
    r             = v;
    tmo           = (T != 0) && (v.waits > T);
    access_cycles = tmo ? T + 1 : v.waits + 1;
    r.e_paddr     = v.addr & 16'hFFFC;
    r.e_pstrb     = v.write ? v.strb : '0;
    r.e_err       = tmo || v.slverr;
    r.e_tmo       = tmo;
    r.e_rdata     = (tmo || v.write) ? '0 : v.prdata;
    r.e_lat       = 2 + access_cycles;
    return r;
  endfunction

  // psel must stay low at least two sampled cycles between transfers.
  int   low_cnt   = 0;
  bit   seen_xfer = 1'b0;
  logic prev_psel = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      seen_xfer = 1'b0;
      low_cnt   = 0;
    end else begin
      if (apb_psel && !prev_psel && seen_xfer)
        check("psel_gap_ge2", 32'(low_cnt >= 2), 32'd1);
      if (apb_penable)
        check("penable_needs_psel", 32'(apb_psel), 32'd1);
      if (apb_psel) begin
        seen_xfer = 1'b1;
        low_cnt   = 0;
      end else begin
        low_cnt++;
      end
    end
    prev_psel = apb_psel;
  end

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic run_txn(input vec_t v, input string tag);
    int            k;
    int            lat;
    int            acc;
    int            n_psel;
    int            n_pen;
    bit            payload_ok;
    bit            stable;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata;
    logic [SW-1:0] s_pstrb;
    logic [2:0]    s_pprot;
    logic          s_pwrite;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic          r_tmo;

    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    cmd_prot  = v.prot;
    k = 0;
    while (!cmd_ready && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      check({tag, ".accept_bound"}, 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = SW'($urandom);
    cmd_prot  = 3'($urandom);

    lat = 1; acc = 0; n_psel = 0; n_pen = 0; payload_ok = 1'b1;
    s_paddr = '0; s_pwdata = '0; s_pstrb = '0; s_pprot = '0; s_pwrite = 1'b0;
    while (!rsp_valid && lat < BOUND) begin
      if (apb_psel) begin
        n_psel++;
        if (n_psel == 1) begin
          s_paddr = apb_paddr; s_pwdata = apb_pwdata; s_pstrb = apb_pstrb;
          s_pprot = apb_pprot; s_pwrite = apb_pwrite;
          check({tag, ".setup_penable"}, 32'(apb_penable), 32'd0);
        end else if (apb_paddr !== s_paddr || apb_pwdata !== s_pwdata || apb_pstrb !== s_pstrb ||
                     apb_pprot !== s_pprot || apb_pwrite !== s_pwrite) begin
          payload_ok = 1'b0;
        end
      end
      if (apb_penable) begin
        n_pen++;
        if (acc == v.waits) begin
          apb_pready = 1'b1; apb_prdata = v.prdata; apb_pslverr = v.slverr;
        end else begin
          apb_pready = 1'b0; apb_prdata = $urandom; apb_pslverr = 1'($urandom);
        end
        acc++;
      end else begin
        apb_pready = 1'($urandom); apb_prdata = $urandom; apb_pslverr = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    apb_pready = 1'b0; apb_pslverr = 1'b0;
    if (!rsp_valid) begin
      check({tag, ".rsp_bound"}, 32'd0, 32'd1);
      return;
    end

    check({tag, ".paddr"},      32'(s_paddr),    32'(v.e_paddr));
    check({tag, ".pstrb"},      32'(s_pstrb),    32'(v.e_pstrb));
    check({tag, ".pwrite"},     32'(s_pwrite),   32'(v.write));
    check({tag, ".pwdata"},     s_pwdata,        v.wdata);
    check({tag, ".pprot"},      32'(s_pprot),    32'(v.prot));
    check({tag, ".payload_hold"}, 32'(payload_ok), 32'd1);
    check({tag, ".psel_cycles"}, 32'(n_psel),    32'(v.e_lat - 1));
    check({tag, ".penable_cycles"}, 32'(n_pen),  32'(v.e_lat - 2));
    check({tag, ".latency"},    32'(lat),        32'(v.e_lat));
    check({tag, ".rsp_err"},    32'(rsp_err),    32'(v.e_err));
    check({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'(v.e_tmo));
    check({tag, ".rsp_rdata"},  rsp_rdata,       v.e_rdata);

    // Offer a command during RESP: it must not be taken before the handshake.
    r_rdata = rsp_rdata; r_err = rsp_err; r_tmo = rsp_timeout;
    stable  = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < v.rsp_delay; i++) begin
      if (!rsp_valid || rsp_rdata !== r_rdata || rsp_err !== r_err || rsp_timeout !== r_tmo ||
          cmd_ready || apb_psel || apb_penable || apb_paddr !== s_paddr || apb_pwdata !== s_pwdata)
        stable = 1'b0;
      @(negedge clk);
    end
    if (v.rsp_delay > 0)
      check({tag, ".rsp_hold"}, 32'(stable), 32'd1);
    check({tag, ".rsp_still_valid"}, 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    int   k;
    int   r;

    //        wr    addr      wdata          strb  prot  wt   prdata         err  dly  paddr     pstrb e_err tmo  rdata         lat
    vecs[0] = '{1'b1, 16'h0006, 32'hDEADBEEF, 4'hF, 3'd0, 0,   32'hAAAA5555, 1'b0, 0, 16'h0004, 4'hF, 1'b0, 1'b0, 32'h0,        3};
    vecs[1] = '{1'b0, 16'h1233, 32'h11111111, 4'hA, 3'd5, 3,   32'h12345678, 1'b0, 1, 16'h1230, 4'h0, 1'b0, 1'b0, 32'h12345678, 6};
    vecs[2] = '{1'b0, 16'h0040, 32'h0,        4'h0, 3'd2, 1,   32'hCAFEF00D, 1'b1, 0, 16'h0040, 4'h0, 1'b1, 1'b0, 32'hCAFEF00D, 4};
    vecs[3] = '{1'b0, 16'h00FF, 32'h0,        4'h0, 3'd1, 100, 32'h55555555, 1'b0, 2, 16'h00FC, 4'h0, 1'b1, 1'b1, 32'h0,        7};
    vecs[4] = '{1'b0, 16'h0200, 32'h0,        4'h0, 3'd0, 4,   32'h0BADF00D, 1'b0, 0, 16'h0200, 4'h0, 1'b0, 1'b0, 32'h0BADF00D, 7};
    vecs[5] = '{1'b1, 16'hFFFF, 32'h01020304, 4'h5, 3'd7, 2,   32'h99999999, 1'b1, 5, 16'hFFFC, 4'h5, 1'b1, 1'b0, 32'h0,        5};
    vecs[6] = '{1'b1, 16'h0010, 32'h00000001, 4'h3, 3'd4, 100, 32'h77777777, 1'b0, 0, 16'h0010, 4'h3, 1'b1, 1'b1, 32'h0,        7};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.cmd_ready",   32'(cmd_ready),   32'd0);
    check("rst.psel",        32'(apb_psel),    32'd0);
    check("rst.penable",     32'(apb_penable), 32'd0);
    check("rst.pwrite",      32'(apb_pwrite),  32'd0);
    check("rst.paddr",       32'(apb_paddr),   32'd0);
    check("rst.pwdata",      apb_pwdata,       32'd0);
    check("rst.pstrb",       32'(apb_pstrb),   32'd0);
    check("rst.pprot",       32'(apb_pprot),   32'd0);
    check("rst.rsp_valid",   32'(rsp_valid),   32'd0);
    check("rst.rsp_err",     32'(rsp_err),     32'd0);
    check("rst.rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst.rsp_rdata",   rsp_rdata,        32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.ready_after_release", 32'(cmd_ready), 32'd1);

    // Directed table, issued back to back.
    for (int i = 0; i < 7; i++)
      run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0300;
    cmd_wdata = 32'hFEEDFACE; cmd_strb = 4'hF; cmd_prot = 3'd0;
    apb_pready = 1'b0;
    k = 0;
    while (!cmd_ready && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rstmid.in_access", 32'(apb_penable), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid.psel",      32'(apb_psel),    32'd0);
    check("rstmid.penable",   32'(apb_penable), 32'd0);
    check("rstmid.rsp_valid", 32'(rsp_valid),   32'd0);
    check("rstmid.cmd_ready", 32'(cmd_ready),   32'd0);
    check("rstmid.paddr",     32'(apb_paddr),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid.ready_after", 32'(cmd_ready), 32'd1);
    check("rstmid.no_rsp",      32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("rstmid.still_no_rsp", 32'(rsp_valid | apb_psel), 32'd0);
    run_txn(vecs[0], "post_rst");

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.write     = 1'($urandom);
      v.addr      = AW'($urandom);
      v.wdata     = $urandom;
      v.strb      = SW'($urandom);
      v.prot      = 3'($urandom);
      r           = int'($urandom_range(0, 9));
      v.waits     = (r < 7) ? int'($urandom_range(0, 3)) : (r == 7) ? T : (r == 8) ? T + 1 : 60;
      v.prdata    = $urandom;
      v.slverr    = ($urandom_range(0, 3) == 0);
      v.rsp_delay = int'($urandom_range(0, 3));
      v = model(v);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
